// File: rtl/chacha_core.sv
// chacha_core: one ChaCha block per accepted start, one round per clock.
// Define CHACHA_REDUCED_ROUNDS_EN for ChaCha8 instead of ChaCha20.
module chacha_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_n,
  output logic [31:0] b_n,
  output logic [31:0] c_n,
  output logic [31:0] d_n
);
  logic [31:0] a1, b1, c1, d1;
  logic [31:0] t0, t1, t2, t3;

  always_comb begin
    a1  = a + b;
    t0  = d ^ a1;
    d1  = {t0[15:0], t0[31:16]};
    c1  = c + d1;
    t1  = b ^ c1;
    b1  = {t1[19:0], t1[31:20]};
    a_n = a1 + b1;
    t2  = d1 ^ a_n;
    d_n = {t2[23:0], t2[31:24]};
    c_n = c1 + d_n;
    t3  = b1 ^ c_n;
    b_n = {t3[24:0], t3[31:25]};
  end
endmodule

module chacha_core (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  output logic         ready_o,
  input  logic [255:0] key_i,
  input  logic [95:0]  nonce_i,
  input  logic [31:0]  counter_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [511:0] keystream_o
);
`ifdef CHACHA_REDUCED_ROUNDS_EN
  localparam logic [4:0] NR = 5'd8;
`else
  localparam logic [4:0] NR = 5'd20;
`endif

  typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

  state_t state_q, state_d;
  logic [4:0] rc_q;
  logic [15:0][31:0] init_q, work_q;
  logic [15:0][31:0] in_state, rnd_d, sum;
  logic [3:0] bi [4];
  logic [3:0] ci [4];
  logic [3:0] di [4];
  logic [31:0] na [4];
  logic [31:0] nb [4];
  logic [31:0] nc [4];
  logic [31:0] nd [4];

  assign in_state = {nonce_i, counter_i, key_i,
                     32'h6b206574, 32'h79622d32,
                     32'h3320646e, 32'h61707865};
  assign ready_o = (state_q == IDLE);

  // odd rounds rotate rows 1..3 by 1..3 lanes to form diagonals
  always_comb begin
    int sh;
    sh = int'(rc_q[0]);
    for (int i = 0; i < 4; i++) begin
      bi[i] = {2'b01, 2'(i + sh)};
      ci[i] = {2'b10, 2'(i + 2 * sh)};
      di[i] = {2'b11, 2'(i + 3 * sh)};
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_qr u_qr (
      .a   (work_q[g]),
      .b   (work_q[bi[g]]),
      .c   (work_q[ci[g]]),
      .d   (work_q[di[g]]),
      .a_n (na[g]),
      .b_n (nb[g]),
      .c_n (nc[g]),
      .d_n (nd[g])
    );
  end

  always_comb begin
    rnd_d = work_q;
    for (int i = 0; i < 4; i++) begin
      rnd_d[i]     = na[i];
      rnd_d[bi[i]] = nb[i];
      rnd_d[ci[i]] = nc[i];
      rnd_d[di[i]] = nd[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sum[i] = work_q[i] + init_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ROUND;
      ROUND:   if (rc_q == NR - 5'd1) state_d = ADD;
      ADD:     state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rc_q        <= '0;
      init_q      <= '0;
      work_q      <= '0;
      keystream_o <= '0;
      valid_o     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            init_q <= in_state;
            work_q <= in_state;
            rc_q   <= '0;
          end
        end
        ROUND: begin
          work_q <= rnd_d;
          rc_q   <= rc_q + 5'd1;
        end
        ADD: begin
          keystream_o <= sum;
          valid_o     <= 1'b1;
        end
        DONE: begin
          if (ready_i) valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/chacha_core.md
CHACHA_CORE -- requirements
Module: chacha_core

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with all state updated on the rising edge of clk_i.
REQ-002 Port clk_i, input, 1 bit: clock.
REQ-003 Port rst_i, input, 1 bit: synchronous active-high reset.
REQ-004 Port start_i, input, 1 bit: request a block; accepted on a rising edge where start_i and ready_o are both 1.
REQ-005 Port ready_o, output, 1 bit: core idle; able to accept start_i.
REQ-006 Port key_i, input, 256 bits: key words 0..7, with key_i[32k+31:32k] as word k.
REQ-007 Port nonce_i, input, 96 bits: nonce words 0..2, same packing.
REQ-008 Port counter_i, input, 32 bits: block counter (state word 12).
REQ-009 Port valid_o, output, 1 bit: keystream_o holds a completed block.
REQ-010 Port ready_i, input, 1 bit: consumer accepts the block; transfer occurs on an edge where valid_o and ready_i are both 1.
REQ-011 Port keystream_o, output, 512 bits: final state words 0..15, with keystream_o[32k+31:32k] as word k.

Function
REQ-012 The core SHALL use a four-state FSM: IDLE, ROUND, ADD, DONE.
REQ-013 On acceptance, the core SHALL sample key_i, nonce_i and counter_i into an initial-state register and a working-state register:
- words 0..3: 61707865, 3320646e, 79622d32, 6b206574
- words 4..11: key
- word 12: counter
- words 13..15: nonce
After sampling, the FSM SHALL go to ROUND and the round counter SHALL be set to 0.
REQ-014 In ROUND, the core SHALL perform one round per cycle using four parallel combinational quarter-round instances:
- even round counter: column round on (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15)
- odd round counter: diagonal round on (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14)
REQ-015 The quarter round SHALL follow RFC 8439, with rotates of 16, 12, 8 and 7 and all additions modulo 2^32.
REQ-016 After round NR-1 completes, the FSM SHALL go to ADD, where NR is 20 by default.
REQ-017 In ADD, the core SHALL register keystream_o as word-wise (working + initial) modulo 2^32, set valid_o to 1, and go to DONE.
REQ-018 Latency SHALL be NR+1 rising edges from the acceptance edge to the edge that sets valid_o; with NR=20 this is 21 edges.
REQ-019 In DONE, keystream_o and valid_o SHALL hold stable until an edge with ready_i=1; that edge SHALL clear valid_o and set the FSM to IDLE.
REQ-020 ready_o SHALL be 1 only in IDLE, so there is no start/complete overlap.
REQ-021 start_i SHALL be ignored while not in IDLE, and no queueing SHALL occur.
REQ-022 key_i, nonce_i and counter_i SHALL be don't-care after acceptance; changes to them SHALL NOT affect the block in flight.
REQ-023 If ready_i is already 1 when valid_o rises, the transfer SHALL complete on the next edge, so valid_o is high for exactly 1 cycle.
REQ-024 The round counter SHALL be 5 bits and SHALL NOT wrap within a block.
REQ-025 keystream_o SHALL retain its last value in IDLE.

Reset
REQ-026 When rst_i=1 at a rising edge, the FSM SHALL go to IDLE and the following SHALL reset:
- ready_o=1
- valid_o=0
- keystream_o=0
- round counter=0
- working-state and initial-state registers=0
REQ-027 Reset SHALL take priority over start_i and ready_i on the same edge.
REQ-028 Reset during ROUND, ADD or DONE SHALL abort the block, and no valid_o SHALL follow.

Configuration
REQ-029 The core SHALL provide exactly one compile-time option, the macro CHACHA_REDUCED_ROUNDS_EN:
- defined: NR=8 (ChaCha8), with latency of 9 edges from acceptance to valid_o
- undefined: NR=20 (ChaCha20), with latency of 21 edges
The option SHALL have no interface change.

Verification
REQ-030 RFC 8439 §2.3.2 vector: key_i words 03020100..1f1e1d1c, nonce_i words 09000000, 4a000000, 00000000, counter_i=1, with ready_i held at 1 -> valid_o rises 21 edges after acceptance; keystream_o word0=e4e7f110, word1=15593bd1, word15=4e3c50a2; valid_o is high for 1 cycle.
REQ-031 Backpressure: same stimulus with ready_i=0 for 10 cycles after valid_o rises -> keystream_o and valid_o are stable throughout; the block transfers on the first edge with ready_i=1; ready_o=1 on the following cycle.
REQ-032 Busy start: pulse start_i with a different counter_i at cycles 5 and 21 after acceptance -> both ignored; the output is unchanged from REQ-030; ready_o=0 at both pulses.
REQ-033 Reset mid-operation: assert rst_i at round 10 -> the next cycle shows ready_o=1, valid_o=0, keystream_o=0; no valid_o within 30 subsequent cycles unless start_i is asserted.
REQ-034 Back-to-back: start_i held at 1 with counter_i=1 then 2, and ready_i held at 1 -> second block accepted in the cycle after the first transfer; its word0 matches RFC 8439 §2.4.2 block 2 (counter 2) computed by the reference model.
REQ-035 With CHACHA_REDUCED_ROUNDS_EN defined: REQ-030 stimulus -> valid_o 9 edges after acceptance; output matches a ChaCha8 reference model.
